// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS control FSM with stall handshake and HALT/ILLEGAL trap states
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   opcode, funct        instruction fields from the instruction register
//   zero                 ALU condition flag (used in BRANCH)
//   mem_ready            memory handshake, 1 = access completes this cycle
//   ALUcntrl             ALU operation select
//   alusrca, alusrcb     ALU operand selects
//   pcsrc                PC source select
//   pc_en .. memtoreg    datapath strobes and selects
//   state                current state encoding (debug)
//   halted, illegal      status flags
module mips_mc_control #(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter logic [5:0] BLT_OP  = 6'b000110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] ALUcntrl,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pc_en,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic [3:0] branch_alu;
  state_t     decode_next;

  // R-type funct decode: legality check and the ALU code it selects
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 4'd3;
    case (funct)
      6'b100100: funct_alu = 4'd0;
      6'b100101: funct_alu = 4'd1;
      6'b100111: funct_alu = 4'd2;
      6'b100000: funct_alu = 4'd3;
      6'b011010: funct_alu = 4'd4;
      6'b100010: funct_alu = 4'd9;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    branch_alu = 4'd9;
    if (opcode == OP_BNE)      branch_alu = 4'd11;
    else if (opcode == BLT_OP) branch_alu = 4'd10;
  end

  always_comb begin
    decode_next = S_ILLEGAL;
    if (opcode == OP_LW || opcode == OP_SW)                        decode_next = S_MEMADR;
    else if (opcode == OP_RTYPE)                                   decode_next = funct_ok ? S_EXEC : S_ILLEGAL;
    else if (opcode == OP_BEQ || opcode == OP_BNE || opcode == BLT_OP) decode_next = S_BRANCH;
    else if (opcode == OP_ADDI)                                    decode_next = S_ADDIEX;
    else if (opcode == OP_J)                                       decode_next = S_JUMP;
    else if (opcode == HALT_OP)                                    decode_next = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:   if (mem_ready) cur <= S_DECODE;
        S_DECODE:  cur <= decode_next;
        S_MEMADR:  cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (mem_ready) cur <= S_MEMWB;
        S_MEMWB:   cur <= S_FETCH;
        S_MEMWR:   if (mem_ready) cur <= S_FETCH;
        S_EXEC:    cur <= S_ALUWB;
        S_ALUWB:   cur <= S_FETCH;
        S_BRANCH:  cur <= S_FETCH;
        S_ADDIEX:  cur <= S_ADDIWB;
        S_ADDIWB:  cur <= S_FETCH;
        S_JUMP:    cur <= S_FETCH;
        S_HALT:    cur <= S_HALT;
        S_ILLEGAL: cur <= S_ILLEGAL;
        default:   cur <= S_FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state register; rst forces the idle
  // pattern immediately so nothing strobes while reset is held.
  always_comb begin
    ALUcntrl = 4'd3;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pc_en    = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    state    = 4'd0;
    if (!rst) begin
      state = cur;
      case (cur)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pc_en   = mem_ready;
        end
        S_DECODE:  alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          iord    = 1'b1;
          memread = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXEC: begin
          alusrca  = 1'b1;
          ALUcntrl = funct_alu;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca  = 1'b1;
          pcsrc    = 2'b01;
          ALUcntrl = branch_alu;
          pc_en    = zero;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB:  regwrite = 1'b1;
        S_JUMP: begin
          ALUcntrl = 4'd12;
          pcsrc    = 2'b10;
          pc_en    = 1'b1;
        end
        S_HALT:    halted  = 1'b1;
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
